// File: rtl/ladybird_serial_loader_if.sv
// Simple request/grant bus shared by the serial byte source and the memory
// write port. The primary raises req with addr/wstrb (and data for writes)
// until gnt; read data returns later on data with a one-cycle data_gnt.
interface ladybird_bus;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    wire  [31:0] data;
    logic        data_gnt;

    modport primary (
        output req,
        output addr,
        output wstrb,
        input  gnt,
        input  data_gnt,
        inout  data
    );

    modport secondary (
        input  req,
        input  addr,
        input  wstrb,
        output gnt,
        output data_gnt,
        inout  data
    );
endinterface

// File: rtl/ladybird_serial_loader.sv
// UART boot loader: pulls bytes from the serial port one read at a time,
// parses WRITE (0x01) and JUMP (0x02) packets, posts 32-bit words to memory
// and reports the jump target as the boot entry address.
module ladybird_serial_loader #(
    parameter logic [31:0] UART_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 16
) (
    input  logic          clk,
    input  logic          anrst,
    input  logic          nrst,
    input  logic          enable,
    ladybird_bus.primary  uart_bus,
    ladybird_bus.primary  mem_bus,
    output logic          busy,
    output logic          error,
    output logic          boot_done,
    output logic [31:0]   boot_addr,
    output logic [31:0]   words_written
);

    typedef enum logic [2:0] {
        CMD   = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        DATA  = 3'd3,
        WR    = 3'd4,
        JADDR = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t             state_reg;
    logic [1:0]         byte_cnt_reg;
    logic [31:0]        shift_reg;
    logic               uart_req_reg;
    logic               wait_reg;
    logic               mem_req_reg;
    logic [31:0]        waddr_reg;
    logic [31:0]        word_reg;
    logic [LEN_W-1:0]   wcnt_reg;
    logic               error_reg;
    logic               boot_done_reg;
    logic [31:0]        boot_addr_reg;
    logic [31:0]        words_reg;

    logic [7:0]         byte_in;
    logic               byte_valid;
    logic [31:0]        assembled;
    logic [LEN_W-1:0]   len_val;

    // Incoming byte shifts in from the top so multi-byte fields land little-endian
    assign byte_in    = uart_bus.data[7:0];
    assign byte_valid = wait_reg && uart_bus.data_gnt;
    assign assembled  = {byte_in, shift_reg[31:8]};
    assign len_val    = LEN_W'(assembled[31:16]);

    // Upper read-data bits and memory data_gnt carry nothing for this block
    wire unused_ok = ^{uart_bus.data[31:8], mem_bus.data_gnt};

    // Packet FSM with the byte-fetch engine folded in; all outputs registered
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_reg     <= CMD;
            byte_cnt_reg  <= 2'd0;
            shift_reg     <= 32'h0;
            uart_req_reg  <= 1'b0;
            wait_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            waddr_reg     <= 32'h0;
            word_reg      <= 32'h0;
            wcnt_reg      <= '0;
            error_reg     <= 1'b0;
            boot_done_reg <= 1'b0;
            boot_addr_reg <= 32'h0;
            words_reg     <= 32'h0;
        end else if (!nrst) begin
            state_reg     <= CMD;
            byte_cnt_reg  <= 2'd0;
            shift_reg     <= 32'h0;
            uart_req_reg  <= 1'b0;
            wait_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            waddr_reg     <= 32'h0;
            word_reg      <= 32'h0;
            wcnt_reg      <= '0;
            error_reg     <= 1'b0;
            boot_done_reg <= 1'b0;
            boot_addr_reg <= 32'h0;
            words_reg     <= 32'h0;
        end else begin
            // Address phase accepted: drop req and wait for the read data
            if (uart_req_reg && uart_bus.gnt) begin
                uart_req_reg <= 1'b0;
                wait_reg     <= 1'b1;
            end

            case (state_reg)
                CMD: begin
                    if (!uart_req_reg && !wait_reg && enable) begin
                        uart_req_reg <= 1'b1;
                    end else if (byte_valid) begin
                        wait_reg     <= 1'b0;
                        byte_cnt_reg <= 2'd0;
                        if (byte_in == 8'h01) begin
                            state_reg    <= ADDR;
                            uart_req_reg <= 1'b1;
                        end else if (byte_in == 8'h02) begin
                            state_reg    <= JADDR;
                            uart_req_reg <= 1'b1;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end

                ADDR, LEN, DATA, JADDR: begin
                    if (byte_valid) begin
                        wait_reg     <= 1'b0;
                        shift_reg    <= assembled;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        uart_req_reg <= 1'b1;
                        if (state_reg == ADDR && byte_cnt_reg == 2'd3) begin
                            waddr_reg <= {assembled[31:2], 2'b00};
                            state_reg <= LEN;
                        end else if (state_reg == LEN && byte_cnt_reg == 2'd1) begin
                            byte_cnt_reg <= 2'd0;
                            if (len_val == '0) begin
                                state_reg    <= CMD;
                                uart_req_reg <= 1'b0;
                            end else begin
                                wcnt_reg  <= len_val;
                                state_reg <= DATA;
                            end
                        end else if (state_reg == DATA && byte_cnt_reg == 2'd3) begin
                            word_reg     <= assembled;
                            mem_req_reg  <= 1'b1;
                            uart_req_reg <= 1'b0;
                            state_reg    <= WR;
                        end else if (state_reg == JADDR && byte_cnt_reg == 2'd3) begin
                            boot_addr_reg <= assembled;
                            boot_done_reg <= 1'b1;
                            uart_req_reg  <= 1'b0;
                            state_reg     <= DONE;
                        end
                    end
                end

                WR: begin
                    if (mem_bus.gnt) begin
                        mem_req_reg  <= 1'b0;
                        waddr_reg    <= waddr_reg + 32'd4;
                        words_reg    <= words_reg + 32'd1;
                        wcnt_reg     <= wcnt_reg - 1'b1;
                        byte_cnt_reg <= 2'd0;
                        if (wcnt_reg != LEN_W'(1)) begin
                            state_reg    <= DATA;
                            uart_req_reg <= 1'b1;
                        end else begin
                            state_reg <= CMD;
                        end
                    end
                end

                default: begin
                    // DONE holds until reset with no bus activity
                end
            endcase
        end
    end

    assign uart_bus.req   = uart_req_reg;
    assign uart_bus.addr  = UART_ADDR;
    assign uart_bus.wstrb = 4'b0000;

    assign mem_bus.req    = mem_req_reg;
    assign mem_bus.addr   = waddr_reg;
    assign mem_bus.wstrb  = {4{mem_req_reg}};
    assign mem_bus.data   = mem_req_reg ? word_reg : 32'hzzzz_zzzz;

    assign busy          = (state_reg != CMD);
    assign error         = error_reg;
    assign boot_done     = boot_done_reg;
    assign boot_addr     = boot_addr_reg;
    assign words_written = words_reg;

endmodule

// File: tb/tb_ladybird_serial_loader.sv
// Scoreboard bench for the serial loader: a UART byte-source model feeds
// directed packets, expected memory writes are queued as packets are issued,
// and a monitor pops and compares whenever a write is granted.
module tb_ladybird_serial_loader;

    logic        clk = 1'b0;
    logic        anrst = 1'b0;
    logic        nrst = 1'b1;
    logic        enable = 1'b0;
    logic        busy;
    logic        error;
    logic        boot_done;
    logic [31:0] boot_addr;
    logic [31:0] words_written;
    logic [31:0] uart_rdata = 32'h0;

    ladybird_bus uart_bus ();
    ladybird_bus mem_bus ();

    assign uart_bus.data = uart_rdata;

    ladybird_serial_loader #(
        .UART_ADDR (32'h0000_0000),
        .LEN_W     (16)
    ) dut (
        .clk           (clk),
        .anrst         (anrst),
        .nrst          (nrst),
        .enable        (enable),
        .uart_bus      (uart_bus),
        .mem_bus       (mem_bus),
        .busy          (busy),
        .error         (error),
        .boot_done     (boot_done),
        .boot_addr     (boot_addr),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          fails = 0;
    logic [7:0]  rx_q[$];
    wr_t         exp_q[$];
    int          mem_stall = 0;
    int          mem_req_cycles = 0;
    int          uart_req_cycles = 0;
    logic [31:0] exp_words = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
        exp_words = exp_words + 32'd1;
    endtask

    // UART byte source: grant when a byte is queued, return it one cycle later
    initial begin
        logic       pending;
        logic [7:0] pbyte;
        pending = 1'b0;
        pbyte = 8'h00;
        uart_bus.gnt = 1'b0;
        uart_bus.data_gnt = 1'b0;
        forever begin
            @(negedge clk);
            uart_bus.gnt = 1'b0;
            uart_bus.data_gnt = 1'b0;
            if (pending) begin
                uart_bus.data_gnt = 1'b1;
                uart_rdata = {24'h0, pbyte};
                pending = 1'b0;
            end else if (uart_bus.req === 1'b1 && rx_q.size() > 0) begin
                uart_bus.gnt = 1'b1;
                pbyte = rx_q.pop_front();
                pending = 1'b1;
            end
        end
    end

    // Memory secondary: optional stall, checks the request holds steady while stalled
    initial begin
        logic        in_write;
        int          stall_left;
        logic [31:0] h_addr;
        logic [31:0] h_data;
        logic [3:0]  h_strb;
        in_write = 1'b0;
        stall_left = 0;
        h_addr = 32'h0;
        h_data = 32'h0;
        h_strb = 4'h0;
        mem_bus.gnt = 1'b0;
        mem_bus.data_gnt = 1'b0;
        forever begin
            @(negedge clk);
            mem_bus.gnt = 1'b0;
            if (mem_bus.req === 1'b1) begin
                mem_req_cycles++;
                if (!in_write) begin
                    in_write = 1'b1;
                    stall_left = mem_stall;
                    h_addr = mem_bus.addr;
                    h_data = mem_bus.data;
                    h_strb = mem_bus.wstrb;
                end else begin
                    check32("wr_stable", {mem_bus.addr ^ h_addr} | {mem_bus.data ^ h_data} | {28'h0, mem_bus.wstrb ^ h_strb}, 32'h0);
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_bus.gnt = 1'b1;
                    in_write = 1'b0;
                end
            end else begin
                in_write = 1'b0;
            end
        end
    end

    // Monitor: compares each granted write against the scoreboard
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (uart_bus.req === 1'b1) uart_req_cycles++;
            if (mem_bus.req === 1'b1) begin
                check32("no_overlap", {31'h0, uart_bus.req}, 32'h0);
            end
            if (mem_bus.req === 1'b1 && mem_bus.gnt === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", mem_bus.addr, mem_bus.data);
                end else begin
                    e = exp_q.pop_front();
                    check32("wr_addr", mem_bus.addr, e.addr);
                    check32("wr_data", mem_bus.data, e.data);
                    check32("wr_strb", {28'h0, mem_bus.wstrb}, 32'hF);
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(rx_q.size() == 0 && exp_q.size() == 0 && busy === 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_timeout: got %0d cycles expected fewer than 3000", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_boot(input string name);
        int n = 0;
        while (boot_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_timeout: got %0d cycles expected fewer than 3000", name, n);
        end
        @(negedge clk);
    endtask

    initial begin
        int m0;
        int u0;
        int n;

        repeat (3) @(negedge clk);
        check32("rst_busy", {31'h0, busy}, 32'h0);
        check32("rst_error", {31'h0, error}, 32'h0);
        check32("rst_boot_done", {31'h0, boot_done}, 32'h0);
        check32("rst_boot_addr", boot_addr, 32'h0);
        check32("rst_words", words_written, 32'h0);
        check32("rst_uart_req", {31'h0, uart_bus.req}, 32'h0);
        check32("rst_mem_req", {31'h0, mem_bus.req}, 32'h0);
        check32("rst_mem_wstrb", {28'h0, mem_bus.wstrb}, 32'h0);
        check32("rst_uart_wstrb", {28'h0, uart_bus.wstrb}, 32'h0);

        anrst = 1'b1;
        repeat (3) @(negedge clk);
        check32("idle_no_fetch", {31'h0, uart_bus.req}, 32'h0);

        // Two-word write to 0x1000
        push_exp(32'h0000_1000, 32'hDEAD_BEEF);
        push_exp(32'h0000_1004, 32'h1234_5678);
        rx_q = {8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        enable = 1'b1;
        wait_idle("write2");
        check32("write2_words", words_written, exp_words);
        check32("write2_busy", {31'h0, busy}, 32'h0);

        // Zero-length write: no memory traffic
        m0 = mem_req_cycles;
        rx_q = {8'h01, 8'h03, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        wait_idle("len0");
        check32("len0_no_mem_req", mem_req_cycles - m0, 32'h0);
        check32("len0_words", words_written, exp_words);

        // Low address bits masked on a real write
        push_exp(32'h0000_2000, 32'hDDCC_BBAA);
        rx_q = {8'h01, 8'h03, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00,
                8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wait_idle("mask");
        check32("mask_words", words_written, exp_words);

        // Memory grant withheld five cycles
        mem_stall = 5;
        m0 = mem_req_cycles;
        push_exp(32'h0000_3000, 32'h1122_3344);
        rx_q = {8'h01, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h00,
                8'h44, 8'h33, 8'h22, 8'h11};
        wait_idle("stall");
        check32("stall_req_cycles", mem_req_cycles - m0, 32'd6);
        check32("stall_words", words_written, exp_words);
        mem_stall = 0;

        // Synchronous reset after two of four data bytes
        rx_q = {8'h01, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        n = 0;
        while (rx_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check32("mid_data_busy", {31'h0, busy}, 32'h1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check32("nrst_busy", {31'h0, busy}, 32'h0);
        check32("nrst_words", words_written, 32'h0);
        check32("nrst_mem_req", {31'h0, mem_bus.req}, 32'h0);
        exp_words = 32'h0;
        push_exp(32'h0000_5000, 32'h0102_0304);
        rx_q = {8'h01, 8'h00, 8'h50, 8'h00, 8'h00, 8'h01, 8'h00,
                8'h04, 8'h03, 8'h02, 8'h01};
        wait_idle("after_nrst");
        check32("after_nrst_words", words_written, exp_words);

        // Jump: boot address captured, loader parks
        rx_q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h80};
        wait_boot("jump");
        check32("jump_boot_addr", boot_addr, 32'h8000_0000);
        check32("jump_boot_done", {31'h0, boot_done}, 32'h1);
        check32("jump_busy", {31'h0, busy}, 32'h1);
        check32("jump_error", {31'h0, error}, 32'h0);
        u0 = uart_req_cycles;
        repeat (20) @(negedge clk);
        check32("done_no_uart_req", uart_req_cycles - u0, 32'h0);
        check32("done_busy", {31'h0, busy}, 32'h1);

        // Async reset releases DONE
        anrst = 1'b0;
        @(negedge clk);
        anrst = 1'b1;
        check32("arst_boot_done", {31'h0, boot_done}, 32'h0);
        check32("arst_busy", {31'h0, busy}, 32'h0);
        check32("arst_boot_addr", boot_addr, 32'h0);

        // Unknown command, then a valid jump
        rx_q = {8'h7F, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wait_boot("err_jump");
        check32("err_sticky", {31'h0, error}, 32'h1);
        check32("err_jump_addr", boot_addr, 32'hDEAD_BEEF);
        check32("err_jump_done", {31'h0, boot_done}, 32'h1);
        check32("exp_q_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
